// File: rtl/key_load_controller.sv
// Key load controller: streams key words into keyStorage one slice per accepted
// transfer and tracks which key registers have been completely loaded.
module key_load_controller (
    input  logic        clock,
    input  logic        resetN,
    input  logic        startLoad,
    input  logic [2:0]  keySelect,
    input  logic        abort,
    input  logic [31:0] dataIn,
    input  logic        dataValid,
    output logic        dataReady,
    output logic [31:0] keyInput,
    output logic [5:0]  writeEnable,
    output logic [4:0]  sliceSelector,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [4:0]  loadedMask
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned WE_W     = 6;
    localparam int unsigned SLICE_W  = 5;
    localparam int unsigned SEL_W    = 3;
    localparam int unsigned NUM_KEYS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [SLICE_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]    key_d;
    logic [SLICE_W-1:0]   slice_d;
    logic [WE_W-1:0]      we_d;
    logic                 error_d;
    logic [NUM_KEYS-1:0]  mask_d;
    logic                 key_valid;

    // Index of the last slice for each key register.
    function automatic logic [SLICE_W-1:0] last_slice(input logic [SEL_W-1:0] sel);
        case (sel)
            3'd0:    return SLICE_W'(3);
            3'd1:    return SLICE_W'(4);
            default: return SLICE_W'(31);
        endcase
    endfunction

    assign key_valid = (keySelect < SEL_W'(NUM_KEYS));
    assign dataReady = (state == LOAD) && !abort;
    assign busy      = (state == LOAD);
    assign done      = (state == DONE);

    // Next-state and next-output logic.
    always_comb begin
        state_d = state;
        sel_d   = sel_q;
        count_d = count_q;
        key_d   = keyInput;
        slice_d = sliceSelector;
        we_d    = '0;
        error_d = 1'b0;
        mask_d  = loadedMask;

        case (state)
            IDLE: begin
                if (startLoad) begin
                    if (key_valid) begin
                        sel_d             = keySelect;
                        count_d           = '0;
                        mask_d[keySelect] = 1'b0;
                        state_d           = LOAD;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (dataValid) begin
                    we_d    = WE_W'(1) << sel_q;
                    key_d   = dataIn;
                    slice_d = count_q;
                    if (count_q == last_slice(sel_q)) begin
                        state_d = DONE;
                    end else begin
                        count_d = count_q + SLICE_W'(1);
                    end
                end
            end
            DONE: begin
                mask_d[sel_q] = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE;
            sel_q         <= '0;
            count_q       <= '0;
            keyInput      <= '0;
            sliceSelector <= '0;
            writeEnable   <= '0;
            error         <= 1'b0;
            loadedMask    <= '0;
        end else begin
            state         <= state_d;
            sel_q         <= sel_d;
            count_q       <= count_d;
            keyInput      <= key_d;
            sliceSelector <= slice_d;
            writeEnable   <= we_d;
            error         <= error_d;
            loadedMask    <= mask_d;
        end
    end

endmodule
